// File: rtl/gmii_pkt_replay.sv
// GMII-side packet replay and capture engine: plays a host-loaded frame with
// programmable gap/count and records the first response frame for readback.
module gmii_pkt_replay #(
    parameter int AW    = 10,
    parameter int GAP_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic [AW:0]      data_len,
    input  logic [GAP_W-1:0] gap,
    input  logic [CNT_W-1:0] count,
    output logic [7:0]       tx_d,
    output logic             tx_dv,
    input  logic [7:0]       rx_d,
    input  logic             rx_dv,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkt_cnt,
    input  logic [AW-1:0]    cap_raddr,
    output logic [7:0]       cap_rdata,
    output logic [AW:0]      cap_len,
    output logic             cap_valid,
    output logic             cap_ovf
);
    typedef enum logic [1:0] {IDLE, GAP, SEND} state_t;

    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    state_t state, state_nxt;

    logic [7:0]       tx_mem  [2**AW];
    logic [7:0]       cap_mem [2**AW];

    logic [AW:0]      len_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] pkt_cnt_inc;
    logic [AW:0]      tx_idx;
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd_q;
    logic             stop_pend;
    logic             start_ok;
    logic             gap_last;
    logic             last_octet;
    logic             finish;

    logic             rx_dv_q;
    logic             armed;
    logic             capturing;
    logic             cap_go;
    logic             cap_full;
    logic             cap_we;

    assign start_ok    = start && !stop && (data_len != '0) && (data_len <= MAX_LEN);
    assign gap_last    = (gap_q <= GAP_W'(1)) || (gap_cnt == gap_q - GAP_W'(1));
    assign last_octet  = (tx_idx == len_q - (AW+1)'(1));
    assign pkt_cnt_inc = pkt_cnt + CNT_W'(1);
    assign finish      = ((count_q != '0) && (pkt_cnt_inc == count_q)) || stop_pend || stop;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = GAP;
            GAP:     if (stop) state_nxt = IDLE;
                     else if (gap_last) state_nxt = SEND;
            SEND:    if (last_octet) state_nxt = finish ? IDLE : GAP;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: tx_d is gated so idle cycles always show zero
    always_comb begin
        tx_dv = (state == SEND);
        busy  = (state != IDLE);
        tx_d  = tx_dv ? rd_q : '0;
    end

    // Read one octet ahead: address 0 during GAP, idx+1 during SEND
    assign rd_addr = (state == SEND) ? tx_idx[AW-1:0] + AW'(1) : '0;

    always_ff @(posedge clk) begin
        if (wr_en && !busy) tx_mem[wr_addr] <= wr_data;
        rd_q <= tx_mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            gap_q     <= '0;
            count_q   <= '0;
            gap_cnt   <= '0;
            tx_idx    <= '0;
            stop_pend <= 1'b0;
            pkt_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state != IDLE) && (state_nxt == IDLE);
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        len_q     <= data_len;
                        gap_q     <= gap;
                        count_q   <= count;
                        pkt_cnt   <= '0;
                        gap_cnt   <= '0;
                        stop_pend <= 1'b0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                    tx_idx  <= '0;
                end
                SEND: begin
                    tx_idx <= tx_idx + (AW+1)'(1);
                    if (stop) stop_pend <= 1'b1;
                    if (last_octet) begin
                        pkt_cnt <= pkt_cnt_inc;
                        gap_cnt <= '0;
                        tx_idx  <= '0;
                        if (finish) stop_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture starts only on a fresh rising edge after arming
    assign cap_go   = armed && (capturing || (rx_dv && !rx_dv_q));
    assign cap_full = cap_len[AW];
    assign cap_we   = cap_go && rx_dv && !cap_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_dv_q   <= 1'b0;
            armed     <= 1'b0;
            capturing <= 1'b0;
            cap_len   <= '0;
            cap_valid <= 1'b0;
            cap_ovf   <= 1'b0;
        end else begin
            rx_dv_q <= rx_dv;
            if (state == IDLE && start_ok) begin
                armed     <= 1'b1;
                capturing <= 1'b0;
                cap_len   <= '0;
                cap_valid <= 1'b0;
                cap_ovf   <= 1'b0;
            end else if (cap_go) begin
                if (rx_dv) begin
                    capturing <= 1'b1;
                    if (cap_full) cap_ovf <= 1'b1;
                    else          cap_len <= cap_len + (AW+1)'(1);
                end else begin
                    capturing <= 1'b0;
                    armed     <= 1'b0;
                    cap_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_we) cap_mem[cap_len[AW-1:0]] <= rx_d;
        cap_rdata <= cap_mem[cap_raddr];
    end

endmodule

// File: tb/tb_gmii_pkt_replay.sv
// Self-checking bench for gmii_pkt_replay: expected tx waveforms are built as
// per-cycle queues from gap/length/count rules; capture is checked against a queue.
module tb_gmii_pkt_replay;
    localparam int AW    = 6;
    localparam int GAP_W = 16;
    localparam int CNT_W = 16;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [7:0]       wr_data;
    logic             start;
    logic             stop;
    logic [AW:0]      data_len;
    logic [GAP_W-1:0] gap;
    logic [CNT_W-1:0] count;
    logic [7:0]       tx_d;
    logic             tx_dv;
    logic [7:0]       rx_d;
    logic             rx_dv;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pkt_cnt;
    logic [AW-1:0]    cap_raddr;
    logic [7:0]       cap_rdata;
    logic [AW:0]      cap_len;
    logic             cap_valid;
    logic             cap_ovf;

    always #5 clk = ~clk;

    gmii_pkt_replay #(.AW(AW), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .data_len(data_len), .gap(gap), .count(count),
        .tx_d(tx_d), .tx_dv(tx_dv), .rx_d(rx_d), .rx_dv(rx_dv),
        .busy(busy), .done(done), .pkt_cnt(pkt_cnt),
        .cap_raddr(cap_raddr), .cap_rdata(cap_rdata), .cap_len(cap_len),
        .cap_valid(cap_valid), .cap_ovf(cap_ovf)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] mem_model [DEPTH];
    logic [7:0] cap_model [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = rnd ? 8'($urandom) : 8'(i);
            mem_model[i] = wr_data;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Expected stream: per frame, max(gap,1) idle cycles then len octets.
    // A stop ends at the stop cycle if idle, else at the end of that frame.
    task automatic run_replay(input int len, input int gp, input int cnt,
                              input int stop_at, input int inf_frames);
        logic       edv [$];
        logic [7:0] ed  [$];
        int ngap, nfr, last, frames;
        ngap = (gp == 0) ? 1 : gp;
        nfr  = (cnt == 0) ? inf_frames : cnt;
        for (int f = 0; f < nfr; f++) begin
            for (int g = 0; g < ngap; g++) begin edv.push_back(1'b0); ed.push_back(8'h00); end
            for (int i = 0; i < len; i++)   begin edv.push_back(1'b1); ed.push_back(mem_model[i]); end
        end
        last = edv.size() - 1;
        if (stop_at >= 0) begin
            last = stop_at;
            if (edv[stop_at]) while (last + 1 < edv.size() && edv[last + 1]) last++;
        end
        frames = 0;
        for (int k = 0; k <= last; k++)
            if (edv[k] && (k == edv.size() - 1 || !edv[k + 1])) frames++;

        @(negedge clk);
        data_len = (AW+1)'(len);
        gap      = GAP_W'(gp);
        count    = CNT_W'(cnt);
        start    = 1'b1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            start   = 1'b0;
            stop    = (c == stop_at);
            wr_en   = (c == 0);
            wr_addr = '0;
            wr_data = ~mem_model[0];
            check($sformatf("tx_c%0d", c), {tx_dv, tx_d}, {edv[c], ed[c]});
            check($sformatf("busy_c%0d", c), busy, 1);
            check($sformatf("done_early_c%0d", c), done, 0);
        end
        @(negedge clk);
        stop  = 1'b0;
        wr_en = 1'b0;
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        check("tx_dv_end", tx_dv, 0);
        check("pkt_cnt", pkt_cnt, frames);
        @(negedge clk);
        check("done_single", done, 0);
        check("tx_dv_after", tx_dv, 0);
    endtask

    task automatic rx_frame(input int n, input bit record);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_dv = 1'b1;
            rx_d  = 8'($urandom);
            if (record) cap_model.push_back(rx_d);
        end
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_capture(input int n_sent);
        int exp_len;
        exp_len = (n_sent > DEPTH) ? DEPTH : n_sent;
        check("cap_valid", cap_valid, 1);
        check("cap_len", cap_len, exp_len);
        check("cap_ovf", cap_ovf, (n_sent > DEPTH));
        for (int a = 0; a < exp_len; a++) begin
            @(negedge clk);
            cap_raddr = AW'(a);
            @(negedge clk);
            check($sformatf("cap_rdata_%0d", a), cap_rdata, cap_model[a]);
        end
    endtask

    task automatic ignored_start(input int len, input bit with_stop);
        @(negedge clk);
        data_len = (AW+1)'(len);
        gap      = GAP_W'(2);
        count    = CNT_W'(1);
        start    = 1'b1;
        stop     = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("ign_busy_l%0d_c%0d", len, c), busy, 0);
            check($sformatf("ign_txdv_l%0d_c%0d", len, c), tx_dv, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        int w;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; data_len = '0; gap = '0; count = '0;
        rx_d = '0; rx_dv = 1'b0; cap_raddr = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_dv", tx_dv, 0);
        check("rst_tx_d", tx_d, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_cap_len", cap_len, 0);
        check("rst_cap_valid", cap_valid, 0);
        check("rst_cap_ovf", cap_ovf, 0);
        rst_n = 1'b1;

        load(1'b0);
        run_replay(64, 100, 1, -1, 0);
        cap_model.delete();
        rx_frame(42, 1'b1);
        rx_frame(30, 1'b0);
        check_capture(42);

        run_replay(60, 12, 3, -1, 0);
        cap_model.delete();
        rx_frame(80, 1'b1);
        check_capture(80);

        load(1'b1);
        run_replay(20, 5, 0, 40, 3);
        run_replay(10, 8, 0, 21, 3);
        for (int r = 0; r < 3; r++)
            run_replay($urandom_range(1, DEPTH), $urandom_range(0, 3), 2, -1, 0);

        // rx already active when capture arms: that frame must be skipped
        @(negedge clk);
        rx_dv = 1'b1;
        rx_d  = 8'hAA;
        run_replay(1, 0, 1, -1, 0);
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (2) @(negedge clk);
        check("partial_cap_valid", cap_valid, 0);
        check("partial_cap_len", cap_len, 0);
        cap_model.delete();
        rx_frame(10, 1'b1);
        check_capture(10);

        ignored_start(0, 1'b0);
        ignored_start(DEPTH + 1, 1'b0);
        ignored_start(8, 1'b1);
        check("ign_keep_cap_valid", cap_valid, 1);
        check("ign_keep_cap_len", cap_len, 10);

        @(negedge clk);
        data_len = (AW+1)'(DEPTH);
        gap      = GAP_W'(2);
        count    = CNT_W'(1);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!tx_dv && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("send_reached", tx_dv, 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_dv", tx_dv, 0);
        check("arst_tx_d", tx_d, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_pkt_cnt", pkt_cnt, 0);
        check("arst_cap_valid", cap_valid, 0);
        check("arst_cap_len", cap_len, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ignored_start(0, 1'b0);
        load(1'b1);
        run_replay(16, 3, 1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gmii_pkt_replay.md
Name: gmii_pkt_replay

Overview:
- Synthesizable GMII-side packet replay and capture engine for on-chip loopback and bring-up of Ethernet-attached blocks.
- Plays a host-loaded frame from internal RAM onto a GMII-style octet stream. Frames can repeat with a programmable inter-packet gap and count.
- Captures the first response frame seen on the receive stream into a second RAM for host readback.
- Sits between a host/register interface and the gmii_rxd/gmii_txd ports of the device under test.

Parameters:
- AW, 10, address width of both buffers; each buffer holds 2^AW octets.
- GAP_W, 16, width of the inter-packet gap counter.
- CNT_W, 16, width of the repeat count and packet counter.

Ports:
- clk  in  1  single clock for all logic (GMII 125 MHz domain).
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  host write strobe into the transmit buffer.
- wr_addr  in  AW  transmit buffer write address.
- wr_data  in  8  transmit buffer write data.
- start  in  1  single-cycle request to begin replay.
- stop  in  1  single-cycle request to end replay.
- data_len  in  AW+1  frame length in octets, 1..2^AW.
- gap  in  GAP_W  idle cycles before each frame.
- count  in  CNT_W  number of frames to send; 0 means run until stop.
- tx_d  out  8  replay octet.
- tx_dv  out  1  replay data valid.
- rx_d  in  8  received octet from the DUT.
- rx_dv  in  1  received data valid.
- busy  out  1  replay in progress.
- done  out  1  one-cycle pulse when replay ends.
- pkt_cnt  out  CNT_W  frames completed since the last accepted start.
- cap_raddr  in  AW  capture buffer read address.
- cap_rdata  out  8  capture buffer data, 1-cycle read latency.
- cap_len  out  AW+1  octets stored for the captured frame.
- cap_valid  out  1  a captured frame is complete.
- cap_ovf  out  1  the captured frame exceeded 2^AW octets.

Behaviour:
- Reset (asynchronous, active-low): state IDLE.
  - tx_dv=0, tx_d=0, busy=0, done=0, pkt_cnt=0.
  - cap_len=0, cap_valid=0, cap_ovf=0, capture disarmed.
  - Buffer contents are undefined after reset.
  - Reset asserted mid-frame drops tx_dv immediately.
- Transmit buffer writes:
  - Accepted only while busy=0.
  - wr_en while busy=1 is ignored.
- State machine IDLE/GAP/SEND:
  - IDLE: start with 1<=data_len<=2^AW latches data_len, gap and count, clears pkt_cnt, arms capture (clears cap_len/cap_valid/cap_ovf), sets busy, and moves to GAP.
  - IDLE: start with data_len=0 or data_len>2^AW is ignored.
  - IDLE: start while busy=1 is ignored.
  - GAP: stays max(gap,1) cycles with tx_dv=0, then moves to SEND.
  - SEND: tx_dv is high for exactly data_len consecutive cycles. tx_d carries buffer octets 0..data_len-1 in order.
  - SEND: the RAM read is pipelined so there are no bubbles. The first tx_dv cycle follows the last GAP cycle directly.
  - On the last octet: pkt_cnt increments.
  - If count!=0 and pkt_cnt reaches count, or stop is pending: go to IDLE, pulse done for 1 cycle, clear busy.
  - Otherwise go back to GAP.
- stop:
  - Never truncates a frame. During SEND it is latched as pending and honoured at end of frame.
  - In GAP it returns to IDLE on the next cycle with a done pulse.
  - In IDLE it has no effect.
- start and stop in the same IDLE cycle: start is ignored.
- Capture:
  - After arming, the first rx_dv rising edge begins capture.
  - Each rx_dv cycle writes rx_d at address cap_len, then increments cap_len.
  - Octets beyond 2^AW are dropped, cap_len saturates at 2^AW, and cap_ovf is set.
  - The rx_dv falling edge sets cap_valid and disarms capture. Later frames are ignored until the next accepted start.
  - If rx_dv is already high when capture is armed, capture waits for the next rising edge, so no partial frame is recorded.
- Replay and capture run independently. Simultaneous tx and rx activity is legal.
- pkt_cnt wraps modulo 2^CNT_W only when count=0.

Test Plan:
- Load 64 octets 0x00..0x3F; start with data_len=64, gap=100, count=1 -> tx_dv idle for 100 cycles, then 64 contiguous cycles carrying 0x00..0x3F; done pulse; pkt_cnt=1; busy=0.
- count=3, gap=12, data_len=60 -> three 60-cycle frames, each separated by exactly 12 idle cycles; pkt_cnt=3; single done pulse.
- count=0, gap=5; assert stop in the middle of the 2nd frame -> 2nd frame completes all data_len octets; done pulse; pkt_cnt=2; no 3rd frame.
- Drive rx_dv for 42 octets, then later a 2nd frame -> cap_valid=1, cap_len=42, cap_rdata matches frame 1; 2nd frame ignored.
- AW=6, rx frame of 80 octets -> cap_len=64, cap_ovf=1, first 64 octets stored.
- Deassert rst_n during SEND -> tx_dv=0 asynchronously; outputs at reset values; subsequent start works normally; start with data_len=0 -> no activity.
